alu_md_unit: RTL



---
 rtl/alu_md_pkg.sv | 46 ++++
 rtl/alu_md_unit_md_iter.sv | 89 ++++++++
 rtl/alu_md_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/alu_md_pkg.sv
// Shared opcode map and FSM state encoding for the ALU / mul-div unit.
package alu_md_pkg;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_NOR   = 5'd5;
  localparam logic [4:0] OP_SLL   = 5'd6;
  localparam logic [4:0] OP_SRL   = 5'd7;
  localparam logic [4:0] OP_SRA   = 5'd8;
  localparam logic [4:0] OP_SLTU  = 5'd9;
  localparam logic [4:0] OP_PASSA = 5'd10;
  localparam logic [4:0] OP_PASSB = 5'd11;
  localparam logic [4:0] OP_BP8   = 5'd12;
  localparam logic [4:0] OP_SLT   = 5'd13;
  localparam logic [4:0] OP_MULTU = 5'd14;
  localparam logic [4:0] OP_MULT  = 5'd15;
  localparam logic [4:0] OP_DIVU  = 5'd16;
  localparam logic [4:0] OP_DIV   = 5'd17;
  localparam logic [4:0] OP_MFHI  = 5'd18;
  localparam logic [4:0] OP_MFLO  = 5'd19;
  localparam logic [4:0] OP_MTHI  = 5'd20;
  localparam logic [4:0] OP_MTLO  = 5'd21;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_e;

  function automatic logic is_mul_op(input logic [4:0] op);
    return (op == OP_MULTU) || (op == OP_MULT);
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

  function automatic logic is_signed_md_op(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_md_unit_md_iter.sv
// Unsigned magnitude datapath: shift-add multiply / restoring divide, one bit per clock.
module md_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic               div_i,
  input  logic [WIDTH-1:0]   a_mag_i,
  input  logic [WIDTH-1:0]   b_mag_i,
  output logic               step_done_o,
  output logic [2*WIDTH-1:0] prod_o,
  output logic [WIDTH-1:0]   quot_o,
  output logic [WIDTH-1:0]   rem_o
);
  localparam int CW = $clog2(WIDTH);

  // acc_hi holds the running upper product / partial remainder,
  // acc_lo holds the multiplier being consumed / quotient being built.
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             div_q, div_d;
  logic             active_q, active_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_shift;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_sub;

  // One iteration step plus the down-counter that terminates after WIDTH steps.
  always_comb begin
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opb_d     = opb_q;
    div_d     = div_q;
    active_d  = active_q;
    cnt_d     = cnt_q;
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    rem_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    rem_ge    = (rem_shift >= {1'b0, opb_q});
    // The partial remainder after a successful subtract is below the divisor, so WIDTH bits suffice.
    rem_sub   = rem_shift[WIDTH-1:0] - opb_q;
    if (load_i) begin
      acc_hi_d = '0;
      acc_lo_d = a_mag_i;
      opb_d    = b_mag_i;
      div_d    = div_i;
      active_d = 1'b1;
      cnt_d    = CW'(WIDTH - 1);
    end else if (active_q) begin
      if (div_q) begin
        acc_hi_d = rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
        acc_lo_d = {acc_lo_q[WIDTH-2:0], rem_ge};
      end else begin
        acc_hi_d = mul_sum[WIDTH:1];
        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
      end
      if (cnt_q == '0) active_d = 1'b0;
      else             cnt_d    = cnt_q - 1'b1;
    end
  end

  // Iteration state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      div_q    <= 1'b0;
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
      div_q    <= div_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

  assign step_done_o = active_q && (cnt_q == '0);
  assign prod_o      = {acc_hi_q, acc_lo_q};
  assign quot_o      = acc_lo_q;
  assign rem_o       = acc_hi_q;

endmodule

// File: rtl/alu_md_unit.sv
// EX-stage ALU with HI/LO and iterative multiply/divide behind a start/busy/done handshake.
//
// state  | meaning
// S_IDLE | accepts start; single-cycle ops and MTHI/MTLO complete here
// S_MUL  | shift-add iterations running in md_iter
// S_DIV  | restoring-divide iterations running in md_iter
// S_FIX  | sign fix-up, HI/LO/result write, done pulse
module alu_md_unit
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic [4:0]       opcode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             z_o,
  output logic             n_o
);
  localparam int SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             z_q, n_q;
  logic             done_q, done_d;
  logic             div_q, div_d;
  logic             neg_pq_q, neg_pq_d;
  logic             neg_r_q, neg_r_d;
  logic             bzero_q, bzero_d;
  logic [WIDTH-1:0] a_q, a_d;

  logic [WIDTH-1:0]   alu_res;
  logic [SHW-1:0]     shamt;
  logic               op_mul, op_div, op_sgn, a_neg, b_neg, md_load;
  logic [WIDTH-1:0]   a_mag, b_mag, quot, rem;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic               step_done;

  assign op_mul  = is_mul_op(opcode_i);
  assign op_div  = is_div_op(opcode_i);
  assign op_sgn  = is_signed_md_op(opcode_i);
  assign a_neg   = op_sgn && a_i[WIDTH-1];
  assign b_neg   = op_sgn && b_i[WIDTH-1];
  assign a_mag   = a_neg ? -a_i : a_i;
  assign b_mag   = b_neg ? -b_i : b_i;
  assign md_load = (state_q == S_IDLE) && start_i && (op_mul || op_div);
  assign shamt   = b_i[SHW-1:0];

  md_iter #(.WIDTH(WIDTH)) u_md_iter (
    .clk_i       (clk_i),
    .rst_ni      (reset_n_i),
    .load_i      (md_load),
    .div_i       (op_div),
    .a_mag_i     (a_mag),
    .b_mag_i     (b_mag),
    .step_done_o (step_done),
    .prod_o      (prod),
    .quot_o      (quot),
    .rem_o       (rem)
  );

  // Single-cycle operation mux; undefined opcodes yield zero.
  always_comb begin
    alu_res = '0;
    case (opcode_i)
      OP_ADD:   alu_res = a_i + b_i;
      OP_SUB:   alu_res = a_i - b_i;
      OP_AND:   alu_res = a_i & b_i;
      OP_OR:    alu_res = a_i | b_i;
      OP_XOR:   alu_res = a_i ^ b_i;
      OP_NOR:   alu_res = ~(a_i | b_i);
      OP_SLL:   alu_res = a_i << shamt;
      OP_SRL:   alu_res = a_i >> shamt;
      OP_SRA:   alu_res = $unsigned($signed(a_i) >>> shamt);
      OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      OP_PASSA: alu_res = a_i;
      OP_PASSB: alu_res = b_i;
      OP_BP8:   alu_res = b_i + WIDTH'(8);
      OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_MFHI:  alu_res = hi_q;
      OP_MFLO:  alu_res = lo_q;
      OP_MTHI:  alu_res = a_i;
      OP_MTLO:  alu_res = a_i;
      default:  alu_res = '0;
    endcase
  end

  // Next-state and register-update logic. A start seen outside S_IDLE is dropped.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    div_d    = div_q;
    neg_pq_d = neg_pq_q;
    neg_r_d  = neg_r_q;
    bzero_d  = bzero_q;
    a_d      = a_q;
    prod_fix = '0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (op_mul || op_div) begin
            state_d  = op_mul ? S_MUL : S_DIV;
            div_d    = op_div;
            neg_pq_d = a_neg ^ b_neg;
            neg_r_d  = a_neg;
            bzero_d  = (b_i == '0);
            a_d      = a_i;
          end else begin
            result_d = alu_res;
            done_d   = 1'b1;
            if (opcode_i == OP_MTHI) hi_d = a_i;
            if (opcode_i == OP_MTLO) lo_d = a_i;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (step_done) state_d = S_FIX;
      end
      S_FIX: begin
        if (!div_q) begin
          prod_fix = neg_pq_q ? -prod : prod;
          hi_d     = prod_fix[2*WIDTH-1:WIDTH];
          lo_d     = prod_fix[WIDTH-1:0];
        end else if (bzero_q) begin
          // Divide by zero: all-ones quotient and the raw dividend as remainder, signed or not.
          lo_d = '1;
          hi_d = a_q;
        end else begin
          lo_d = neg_pq_q ? -quot : quot;
          hi_d = neg_r_q ? -rem : rem;
        end
        result_d = lo_d;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Architectural and control registers; reset clears everything including any op in flight.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      done_q   <= 1'b0;
      div_q    <= 1'b0;
      neg_pq_q <= 1'b0;
      neg_r_q  <= 1'b0;
      bzero_q  <= 1'b0;
      a_q      <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      z_q      <= (result_d == '0);
      n_q      <= result_d[WIDTH-1];
      done_q   <= done_d;
      div_q    <= div_d;
      neg_pq_q <= neg_pq_d;
      neg_r_q  <= neg_r_d;
      bzero_q  <= bzero_d;
      a_q      <= a_d;
    end
  end

  assign busy_o   = (state_q == S_MUL) || (state_q == S_DIV);
  assign done_o   = done_q;
  assign result_o = result_q;
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;
  assign z_o      = z_q;
  assign n_o      = n_q;

endmodule
